// File: rtl/tt6581_pkg.sv
// Shared SPI frame geometry and FSM state type for the tt6581 SPI master.
// Optional feature macro used by the master: SPI_MISO_SYNC_EN.
package tt6581_pkg;

   localparam int SPI_FRAME_W = 16;
   localparam int SPI_ADDR_W  = 7;
   localparam int SPI_DATA_W  = 8;
   localparam int SPI_RW_BIT  = 15;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_SHIFT,
      ST_HOLD,
      ST_GAP
   } spi_state_e;

   // Reads always send a zero data byte.
   function automatic logic [SPI_FRAME_W-1:0] build_frame(
      input logic                  we,
      input logic [SPI_ADDR_W-1:0] addr,
      input logic [SPI_DATA_W-1:0] wdata
   );
      return {we, addr, (we ? wdata : {SPI_DATA_W{1'b0}})};
   endfunction

endpackage

// File: rtl/tt6581_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input.
// Instantiated by the SPI master only when SPI_MISO_SYNC_EN is defined.
module tt6581_sync2 (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/tt6581_spi_master.sv
// SPI mode-0 initiator issuing one 16-bit register frame per accepted request.
// SPI_MISO_SYNC_EN: route miso_i through a 2-flop synchroniser and sample it later.
module tt6581_spi_master
   import tt6581_pkg::*;
#(
   parameter int CLK_DIV = 4,
   parameter int CS_GAP  = 2
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic                  req_we_i,
   input  logic [SPI_ADDR_W-1:0] req_addr_i,
   input  logic [SPI_DATA_W-1:0] req_wdata_i,
   output logic                  rsp_valid_o,
   output logic [SPI_DATA_W-1:0] rsp_rdata_o,
   output logic                  busy_o,
   output logic                  sclk_o,
   output logic                  cs_no,
   output logic                  mosi_o,
   input  logic                  miso_i
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

   if (CLK_DIV < 2) begin : g_bad_div
      $error("tt6581_spi_master: CLK_DIV must be >= 2");
   end
   if (CS_GAP < 1) begin : g_bad_gap
      $error("tt6581_spi_master: CS_GAP must be >= 1");
   end

   spi_state_e                  state_q, state_d;
   logic [DIV_W-1:0]            div_cnt_q, div_cnt_d;
   logic [4:0]                  bit_cnt_q, bit_cnt_d;
   logic [GAP_W-1:0]            gap_cnt_q, gap_cnt_d;
   logic [SPI_FRAME_W-2:0]      shift_q, shift_d;
   logic [SPI_DATA_W-1:0]       rx_q, rx_d;
   logic [SPI_DATA_W-1:0]       rdata_q, rdata_d;
   logic                        sclk_q, sclk_d;
   logic                        cs_n_q, cs_n_d;
   logic                        mosi_q, mosi_d;
   logic                        rsp_valid_q, rsp_valid_d;
   logic                        busy_q, busy_d;
   logic                        ready_q, ready_d;
   logic                        div_end;
   logic                        sample_en;
   logic                        miso_s;
   logic [SPI_FRAME_W-1:0]      frame;

   assign div_end = (div_cnt_q == DIV_W'(CLK_DIV - 1));
   assign frame   = build_frame(req_we_i, req_addr_i, req_wdata_i);

`ifdef SPI_MISO_SYNC_EN
   if (CLK_DIV < 3) begin : g_bad_sync_div
      $error("tt6581_spi_master: CLK_DIV must be >= 3 with SPI_MISO_SYNC_EN");
   end

   tt6581_sync2 u_miso_sync (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .d_i   (miso_i),
      .q_o   (miso_s)
   );

   // Synchroniser output reflects the level at the rising edge two clocks later.
   assign sample_en = (state_q == ST_SHIFT) && sclk_q && (div_cnt_q == DIV_W'(1));
`else
   assign miso_s    = miso_i;
   assign sample_en = div_end && (((state_q == ST_SETUP)) ||
                                  ((state_q == ST_SHIFT) && !sclk_q));
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= ST_IDLE;
         div_cnt_q   <= '0;
         bit_cnt_q   <= '0;
         gap_cnt_q   <= '0;
         shift_q     <= '0;
         rx_q        <= '0;
         rdata_q     <= '0;
         sclk_q      <= 1'b0;
         cs_n_q      <= 1'b1;
         mosi_q      <= 1'b0;
         rsp_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         ready_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         div_cnt_q   <= div_cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         gap_cnt_q   <= gap_cnt_d;
         shift_q     <= shift_d;
         rx_q        <= rx_d;
         rdata_q     <= rdata_d;
         sclk_q      <= sclk_d;
         cs_n_q      <= cs_n_d;
         mosi_q      <= mosi_d;
         rsp_valid_q <= rsp_valid_d;
         busy_q      <= busy_d;
         ready_q     <= ready_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      div_cnt_d   = div_cnt_q;
      bit_cnt_d   = bit_cnt_q;
      gap_cnt_d   = gap_cnt_q;
      shift_d     = shift_q;
      rdata_d     = rdata_q;
      sclk_d      = sclk_q;
      cs_n_d      = cs_n_q;
      mosi_d      = mosi_q;
      rsp_valid_d = 1'b0;
      rx_d        = sample_en ? {rx_q[SPI_DATA_W-2:0], miso_s} : rx_q;

      case (state_q)
         ST_IDLE: begin
            if (req_valid_i && ready_q) begin
               state_d   = ST_SETUP;
               shift_d   = frame[SPI_FRAME_W-2:0];
               mosi_d    = frame[SPI_RW_BIT];
               cs_n_d    = 1'b0;
               sclk_d    = 1'b0;
               div_cnt_d = '0;
               bit_cnt_d = '0;
            end
         end
         ST_SETUP: begin
            if (div_end) begin
               state_d   = ST_SHIFT;
               sclk_d    = 1'b1;
               div_cnt_d = '0;
            end else begin
               div_cnt_d = div_cnt_q + DIV_W'(1);
            end
         end
         ST_SHIFT: begin
            if (!div_end) begin
               div_cnt_d = div_cnt_q + DIV_W'(1);
            end else begin
               div_cnt_d = '0;
               if (sclk_q) begin
                  // Falling edge: either finish after bit 0 or present the next bit.
                  sclk_d = 1'b0;
                  if (bit_cnt_q == 5'd15) begin
                     state_d = ST_HOLD;
                     mosi_d  = 1'b0;
                  end else begin
                     bit_cnt_d = bit_cnt_q + 5'd1;
                     mosi_d    = shift_q[SPI_FRAME_W-2];
                     shift_d   = {shift_q[SPI_FRAME_W-3:0], 1'b0};
                  end
               end else begin
                  sclk_d = 1'b1;
               end
            end
         end
         ST_HOLD: begin
            if (div_end) begin
               state_d     = ST_GAP;
               cs_n_d      = 1'b1;
               rsp_valid_d = 1'b1;
               rdata_d     = rx_q;
               gap_cnt_d   = '0;
            end else begin
               div_cnt_d = div_cnt_q + DIV_W'(1);
            end
         end
         ST_GAP: begin
            if (gap_cnt_q == GAP_W'(CS_GAP - 1)) begin
               state_d = ST_IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q + GAP_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            cs_n_d  = 1'b1;
            sclk_d  = 1'b0;
            mosi_d  = 1'b0;
         end
      endcase

      ready_d = (state_d == ST_IDLE);
      busy_d  = (state_d != ST_IDLE);
   end

   assign req_ready_o = ready_q;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_rdata_o = rdata_q;
   assign busy_o      = busy_q;
   assign sclk_o      = sclk_q;
   assign cs_no       = cs_n_q;
   assign mosi_o      = mosi_q;

endmodule

// File: tb/tb_tt6581_spi_master.sv
// Scoreboard bench for tt6581_spi_master: random register traffic against a
// behavioural SPI target, with a register-level reference model predicting responses.
module tb_tt6581_spi_master;

   localparam int CLK_DIV   = 4;
   localparam int CS_GAP    = 2;
   localparam int CS_LOW    = 33 * CLK_DIV;
   localparam int RSP_LAT   = 1 + 33 * CLK_DIV;
   localparam int B2B_SPACE = 1 + 33 * CLK_DIV + CS_GAP;

   logic       clk_i = 1'b0;
   logic       rst_i = 1'b1;
   logic       req_valid_i = 1'b0;
   logic       req_ready_o;
   logic       req_we_i = 1'b0;
   logic [6:0] req_addr_i = '0;
   logic [7:0] req_wdata_i = '0;
   logic       rsp_valid_o;
   logic [7:0] rsp_rdata_o;
   logic       busy_o;
   logic       sclk_o;
   logic       cs_no;
   logic       mosi_o;
   logic       miso_i = 1'b0;

   tt6581_spi_master #(.CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .req_valid_i (req_valid_i),
      .req_ready_o (req_ready_o),
      .req_we_i    (req_we_i),
      .req_addr_i  (req_addr_i),
      .req_wdata_i (req_wdata_i),
      .rsp_valid_o (rsp_valid_o),
      .rsp_rdata_o (rsp_rdata_o),
      .busy_o      (busy_o),
      .sclk_o      (sclk_o),
      .cs_no       (cs_no),
      .mosi_o      (mosi_o),
      .miso_i      (miso_i)
   );

   always #5 clk_i = ~clk_i;

   int cycle = 0;
   always @(posedge clk_i) cycle <= cycle + 1;

   typedef struct {
      logic [15:0] frame;
      logic [7:0]  rdata;
      int          rsp_cycle;
   } exp_t;

   exp_t        scoreboard[$];
   logic [15:0] seen_frames[$];
   logic [7:0]  fill_bytes[$];
   logic [7:0]  model_regs[128];
   logic [7:0]  target_regs[128];

   int n_vec = 0;
   int n_err = 0;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
      end
   endtask

   // Behavioural mode-0 target: shifts MOSI on rising SCLK, drives MISO on falling SCLK.
   int          t_cnt = 0;
   logic [15:0] t_sh = '0;
   logic [7:0]  t_out = '0;

   always @(negedge cs_no) begin
      t_cnt  = 0;
      t_sh   = '0;
      miso_i = 1'($urandom_range(0, 1));
   end

   always @(posedge sclk_o) begin
      if (!cs_no) begin
         t_sh = {t_sh[14:0], mosi_o};
         t_cnt++;
      end
   end

   always @(negedge sclk_o) begin
      if (!cs_no) begin
         if (t_cnt == 8) begin
            if (t_sh[7]) t_out = (fill_bytes.size() > 0) ? fill_bytes.pop_front() : 8'h00;
            else         t_out = target_regs[t_sh[6:0]];
            miso_i = t_out[7];
         end else if (t_cnt > 8 && t_cnt < 16) begin
            miso_i = t_out[3'(15 - t_cnt)];
         end else if (t_cnt < 8) begin
            miso_i = 1'($urandom_range(0, 1));
         end else begin
            miso_i = 1'b0;
         end
      end
   end

   always @(posedge cs_no) begin
      if (t_cnt == 16) begin
         seen_frames.push_back(t_sh);
         if (t_sh[15]) target_regs[t_sh[14:8]] = t_sh[7:0];
      end
      t_cnt = 0;
   end

   // Monitor: pops the scoreboard whenever a response pulse appears.
   int  cs_cnt   = 0;
   bit  cs_prev  = 1'b1;
   bit  prev_rsp = 1'b0;

   always @(negedge clk_i) begin
      exp_t        e;
      logic [15:0] f;
      if (rst_i) begin
         cs_prev  = 1'b1;
         prev_rsp = 1'b0;
      end else begin
         if (!cs_no) cs_cnt = cs_prev ? 1 : cs_cnt + 1;
         cs_prev = cs_no;
         if (prev_rsp) checkOutput("rsp_pulse_width", 32'(rsp_valid_o), 32'd0);
         if (rsp_valid_o) begin
            if (scoreboard.size() == 0) begin
               checkOutput("unexpected_rsp", 32'(rsp_valid_o), 32'd0);
            end else begin
               e = scoreboard.pop_front();
               checkOutput("rsp_rdata", 32'(rsp_rdata_o), 32'(e.rdata));
               checkOutput("rsp_cycle", 32'(cycle), 32'(e.rsp_cycle));
               checkOutput("cs_low_len", 32'(cs_cnt), 32'(CS_LOW));
               checkOutput("busy_at_rsp", 32'(busy_o), 32'd1);
               if (seen_frames.size() == 0) begin
                  checkOutput("frame_missing", 32'(seen_frames.size()), 32'd1);
               end else begin
                  f = seen_frames.pop_front();
                  checkOutput("mosi_frame", 32'(f), 32'(e.frame));
               end
            end
         end
         prev_rsp = rsp_valid_o;
      end
   end

   // Issues one request; the reference model decides frame and response data.
   task automatic applyStimulus(input logic we, input logic [6:0] addr, input logic [7:0] wdata,
                                input bit keep, output int acc);
      exp_t e;
      logic [7:0] fill;
      bit   done = 1'b0;
      acc         = -1;
      req_valid_i = 1'b1;
      req_we_i    = we;
      req_addr_i  = addr;
      req_wdata_i = wdata;
      fill        = 8'($urandom);
      e.frame     = {we, addr, (we ? wdata : 8'h00)};
      if (we) begin
         fill_bytes.push_back(fill);
         e.rdata = fill;
         model_regs[addr] = wdata;
      end else begin
         e.rdata = model_regs[addr];
      end
      for (int i = 0; i < 1000 && !done; i++) begin
         @(negedge clk_i);
         if (req_ready_o) begin
            acc         = cycle;
            e.rsp_cycle = cycle + RSP_LAT;
            scoreboard.push_back(e);
            done = 1'b1;
         end
      end
      if (!done) checkOutput("accept_timeout", 32'd0, 32'd1);
      @(posedge clk_i);
      #1;
      if (!keep || !done) req_valid_i = 1'b0;
   endtask

   initial begin
      int acc;
      int prev_acc;
      bit found;
      for (int i = 0; i < 128; i++) begin
         model_regs[i]  = 8'h00;
         target_regs[i] = 8'h00;
      end

      #23;
      checkOutput("reset_cs_no",  32'(cs_no),       32'd1);
      checkOutput("reset_sclk",   32'(sclk_o),      32'd0);
      checkOutput("reset_mosi",   32'(mosi_o),      32'd0);
      checkOutput("reset_rsp",    32'(rsp_valid_o), 32'd0);
      checkOutput("reset_rdata",  32'(rsp_rdata_o), 32'd0);
      checkOutput("reset_busy",   32'(busy_o),      32'd0);
      checkOutput("reset_ready",  32'(req_ready_o), 32'd0);
      @(posedge clk_i);
      #1 rst_i = 1'b0;
      @(negedge clk_i);
      checkOutput("ready_after_release0", 32'(req_ready_o), 32'd0);
      @(negedge clk_i);
      checkOutput("ready_after_release1", 32'(req_ready_o), 32'd1);
      @(posedge clk_i);
      #1;

      // Directed: write 0x05<-0xA5, then 0x12<-0x3C and read it back.
      applyStimulus(1'b1, 7'h05, 8'hA5, 1'b0, acc);
      applyStimulus(1'b1, 7'h12, 8'h3C, 1'b0, acc);
      applyStimulus(1'b0, 7'h12, 8'hFF, 1'b0, acc);
      applyStimulus(1'b1, 7'h18, 8'h0F, 1'b0, acc);
      applyStimulus(1'b0, 7'h18, 8'h00, 1'b0, acc);

      // Back-to-back batch: valid held high, accepts must be evenly spaced.
      prev_acc = -1;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'($urandom_range(0, 1)), 7'($urandom), 8'($urandom), (i != 3), acc);
         if (prev_acc >= 0 && acc >= 0) checkOutput("b2b_spacing", 32'(acc - prev_acc), 32'(B2B_SPACE));
         prev_acc = acc;
      end

      // Mid-frame reset during bit 7 of a read: abort at once, no response.
      req_valid_i = 1'b1;
      req_we_i    = 1'b0;
      req_addr_i  = 7'h33;
      found       = 1'b0;
      for (int i = 0; i < 1000 && !found; i++) begin
         @(negedge clk_i);
         if (req_ready_o) found = 1'b1;
      end
      @(posedge clk_i);
      #1 req_valid_i = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 1000 && !found; i++) begin
         @(negedge clk_i);
         if (t_cnt == 8) found = 1'b1;
      end
      checkOutput("abort_reached_bit7", 32'(found), 32'd1);
      @(posedge clk_i);
      #1 rst_i = 1'b1;
      #1;
      checkOutput("abort_cs_no", 32'(cs_no),       32'd1);
      checkOutput("abort_sclk",  32'(sclk_o),      32'd0);
      checkOutput("abort_busy",  32'(busy_o),      32'd0);
      checkOutput("abort_rsp",   32'(rsp_valid_o), 32'd0);
      repeat (3) @(posedge clk_i);
      #1 rst_i = 1'b0;
      @(negedge clk_i);
      checkOutput("abort_ready0", 32'(req_ready_o), 32'd0);
      @(negedge clk_i);
      checkOutput("abort_ready1", 32'(req_ready_o), 32'd1);
      @(posedge clk_i);
      #1;

      // Random traffic concentrated on a few addresses so reads hit earlier writes.
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'($urandom_range(0, 1)), 7'($urandom_range(0, 7) * 16 + 3),
                       8'($urandom), 1'b0, acc);
         repeat ($urandom_range(0, 3)) @(posedge clk_i);
         #1;
      end

      for (int i = 0; i < 3000 && scoreboard.size() != 0; i++) @(posedge clk_i);
      repeat (5) @(posedge clk_i);
      checkOutput("scoreboard_drained", 32'(scoreboard.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
